sdcard_spi_target: RTL and testbench

SPI-mode-0 target (card side) of the SD-card SPI link. It oversamples the incoming sclk, cs_n and mosi in the system clock domain and deserialises bytes. It frames 6-byte SD commands (start bits 01, index, 32-bit argument, CRC7, end bit) and serialises queued response bytes on miso, sending 0xFF when the queue is empty. It is used as an on-board card emulator and as the bench responder for the SD host path.

---
 rtl/sdcard_spi_target.sv | 183 ++++++++++++++++++
 tb/tb_sdcard_spi_target.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sdcard_spi_target.sv
// sdcard_spi_target: SD-card SPI mode-0 target with command framing and response FIFO.
// Define CRC7_CHECK_EN to verify the CRC7 of received command frames.
module sdcard_spi_target #(
  parameter int RESP_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic [6:0]  cmd_crc,
  output logic        cmd_crc_ok,
  input  logic [7:0]  resp_data,
  input  logic        resp_wr,
  output logic        resp_full,
  output logic        resp_overflow,
  input  logic        resp_flush
);
  localparam int AW = $clog2(RESP_DEPTH);
  localparam logic [AW:0] ONE = 1;
  typedef enum logic {IDLE, COLLECT} state_t;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
  logic sclk_prev_q, cs_prev_q, miso_oe_q, miso_oe_d, rx_valid_q, rx_valid_d, cmd_valid_q, cmd_valid_d;
  logic cmd_crc_ok_q, cmd_crc_ok_d, resp_full_q, resp_full_d, resp_overflow_q, resp_overflow_d;
  logic [2:0] bit_cnt_q, bit_cnt_d, cnt_q, cnt_d;
  logic [6:0] rx_sh_q, rx_sh_d, cmd_crc_q, cmd_crc_d, crc_q, crc_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_data_q, rx_data_d, rx_byte, head, next_tx;
  logic [5:0] cmd_index_q, cmd_index_d, idx_q, idx_d;
  logic [31:0] cmd_arg_q, cmd_arg_d, arg_q, arg_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0] mem_q [RESP_DEPTH];
  state_t state_q, state_d;
  logic sclk_s, cs_s, mosi_s, cs_fall, cs_rise, sclk_rise, sclk_fall, byte_done, pop, pop_ok, push_ok;
`ifdef CRC7_CHECK_EN
  function automatic logic [6:0] crc7(input logic [6:0] c, input logic [7:0] b);
    logic [6:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) r = {r[5:0], 1'b0} ^ ((r[6] ^ b[i]) ? 7'h09 : 7'h00);
    return r;
  endfunction
`endif
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s & ~cs_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s & ~cs_s & ~cs_fall;
  assign byte_done = sclk_rise & (bit_cnt_q == 3'd7);
  assign rx_byte   = {rx_sh_q, mosi_s};
  assign pop       = cs_fall | (sclk_fall & (bit_cnt_q == 3'd0));
  assign pop_ok    = pop & (wr_ptr_q != rd_ptr_q);
  assign push_ok   = resp_wr & ~resp_flush & (~resp_full_q | pop_ok);
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign next_tx   = pop_ok ? head : 8'hFF;
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    miso_oe_d   = cs_fall | (miso_oe_q & ~cs_rise);
    bit_cnt_d   = (cs_fall | cs_rise) ? 3'd0 : sclk_rise ? bit_cnt_q + 3'd1 : bit_cnt_q;
    rx_sh_d     = sclk_rise ? rx_byte[6:0] : rx_sh_q;
    rx_data_d   = byte_done ? rx_byte : rx_data_q;
    rx_valid_d  = byte_done;
    tx_sh_d     = cs_rise ? 8'hFF : pop ? next_tx : sclk_fall ? {tx_sh_q[6:0], 1'b1} : tx_sh_q;
    wr_ptr_d    = resp_flush ? '0 : push_ok ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d    = resp_flush ? '0 : pop_ok ? rd_ptr_q + ONE : rd_ptr_q;
    resp_full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    resp_overflow_d = ~resp_flush & (resp_overflow_q | (resp_wr & ~push_ok));
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    arg_d        = arg_q;
    crc_d        = crc_q;
    cmd_valid_d  = 1'b0;
    cmd_index_d  = cmd_index_q;
    cmd_arg_d    = cmd_arg_q;
    cmd_crc_d    = cmd_crc_q;
    cmd_crc_ok_d = cmd_crc_ok_q;
    if (cs_rise) state_d = IDLE;
    else if (byte_done && state_q == IDLE && rx_byte[7:6] == 2'b01) begin
      state_d = COLLECT;
      cnt_d   = 3'd1;
      idx_d   = rx_byte[5:0];
`ifdef CRC7_CHECK_EN
      crc_d   = crc7(7'd0, rx_byte);
`endif
    end else if (byte_done && state_q == COLLECT && cnt_q != 3'd5) begin
      cnt_d = cnt_q + 3'd1;
      arg_d = {arg_q[23:0], rx_byte};
`ifdef CRC7_CHECK_EN
      crc_d = crc7(crc_q, rx_byte);
`endif
    end else if (byte_done && state_q == COLLECT) begin
      state_d     = IDLE;
      cmd_valid_d = 1'b1;
      cmd_index_d = idx_q;
      cmd_arg_d   = arg_q;
      cmd_crc_d   = rx_byte[7:1];
`ifdef CRC7_CHECK_EN
      cmd_crc_ok_d = rx_byte[0] & (crc_q == rx_byte[7:1]);
`else
      cmd_crc_ok_d = rx_byte[0];
`endif
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      cs_sync_q <= '1;
      mosi_sync_q <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q <= 1'b1;
      miso_oe_q <= 1'b0;
      bit_cnt_q <= '0;
      rx_sh_q <= '0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      tx_sh_q <= 8'hFF;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      resp_full_q <= 1'b0;
      resp_overflow_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      arg_q <= '0;
      crc_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_index_q <= '0;
      cmd_arg_q <= '0;
      cmd_crc_q <= '0;
      cmd_crc_ok_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_s;
      cs_prev_q <= cs_s;
      miso_oe_q <= miso_oe_d;
      bit_cnt_q <= bit_cnt_d;
      rx_sh_q <= rx_sh_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_sh_q <= tx_sh_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      resp_full_q <= resp_full_d;
      resp_overflow_q <= resp_overflow_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      arg_q <= arg_d;
      crc_q <= crc_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_index_q <= cmd_index_d;
      cmd_arg_q <= cmd_arg_d;
      cmd_crc_q <= cmd_crc_d;
      cmd_crc_ok_q <= cmd_crc_ok_d;
    end
  end
  // storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk) if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= resp_data;
  assign miso          = tx_sh_q[7];
  assign miso_oe       = miso_oe_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign cmd_valid     = cmd_valid_q;
  assign cmd_index     = cmd_index_q;
  assign cmd_arg       = cmd_arg_q;
  assign cmd_crc       = cmd_crc_q;
  assign cmd_crc_ok    = cmd_crc_ok_q;
  assign resp_full     = resp_full_q;
  assign resp_overflow = resp_overflow_q;
endmodule

// File: tb/tb_sdcard_spi_target.sv
// tb_sdcard_spi_target: scoreboard bench for sdcard_spi_target driving SPI as the host.
`timescale 1ns/1ps
module tb_sdcard_spi_target;
  logic clk = 0, rst = 0, sclk = 0, cs_n = 1, mosi = 1, resp_wr = 0, resp_flush = 0;
  logic [7:0] resp_data = 0;
  logic miso, miso_oe, rx_valid, cmd_valid, cmd_crc_ok, resp_full, resp_overflow;
  logic [7:0] rx_data;
  logic [5:0] cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0] cmd_crc;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic        ok;
  } cmd_t;
  logic [7:0] exp_rx[$];
  cmd_t exp_cmd[$];
`ifdef CRC7_CHECK_EN
  localparam logic CRC_EN = 1'b1;
`else
  localparam logic CRC_EN = 1'b0;
`endif
  always #5 clk = ~clk;
  sdcard_spi_target dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .cmd_valid(cmd_valid), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .cmd_crc(cmd_crc), .cmd_crc_ok(cmd_crc_ok), .resp_data(resp_data),
    .resp_wr(resp_wr), .resp_full(resp_full), .resp_overflow(resp_overflow), .resp_flush(resp_flush)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic xfer(input logic [7:0] tx, input logic [7:0] exp_miso);
    logic [7:0] rd;
    exp_rx.push_back(tx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      wait_clk(8);
      sclk = 1;
      rd[i] = miso;
      wait_clk(8);
      sclk = 0;
    end
    chk("miso_byte", rd, exp_miso);
  endtask
  task automatic send_cmd(input logic [47:0] fr, input logic ok, input logic [7:0] first_miso);
    exp_cmd.push_back({fr[45:40], fr[39:8], fr[7:1], ok});
    for (int i = 5; i >= 0; i--) xfer(fr[i*8 +: 8], i == 5 ? first_miso : 8'hFF);
  endtask
  task automatic cs_hi();
    wait_clk(8);
    cs_n = 1;
    wait_clk(8);
  endtask
  task automatic push(input logic [7:0] b);
    @(negedge clk);
    resp_data = b;
    resp_wr = 1;
    @(negedge clk);
    resp_wr = 0;
  endtask
  task automatic chk_reset_outputs();
    chk("rst_miso", miso, 1);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_index", cmd_index, 0);
    chk("rst_cmd_arg", cmd_arg, 0);
    chk("rst_cmd_crc", cmd_crc, 0);
    chk("rst_cmd_crc_ok", cmd_crc_ok, 0);
    chk("rst_resp_full", resp_full, 0);
    chk("rst_resp_overflow", resp_overflow, 0);
  endtask
  always @(negedge clk) if (rst) begin
    if (rx_valid) begin
      if (exp_rx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected actual=%0h required=none", rx_data);
      end else chk("rx_data", rx_data, exp_rx.pop_front());
    end
    if (cmd_valid) begin
      if (exp_cmd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cmd_unexpected actual=%0h required=none", cmd_index);
      end else begin
        cmd_t e;
        e = exp_cmd.pop_front();
        chk("cmd_index", cmd_index, e.idx);
        chk("cmd_arg", cmd_arg, e.arg);
        chk("cmd_crc", cmd_crc, e.crc);
        chk("cmd_crc_ok", cmd_crc_ok, e.ok);
        chk("cmd_with_rx_valid", rx_valid, 1);
      end
    end
  end
  initial begin
    #1ms;
    $display("FAIL timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end
  initial begin
    wait_clk(3);
    chk_reset_outputs();
    rst = 1;
    wait_clk(5);
    cs_n = 0;
    wait_clk(1);
    wait_clk(4);
    chk("miso_oe_active", miso_oe, 1);
    send_cmd(48'h40_0000_0000_95, 1'b1, 8'hFF);
    cs_hi();
    chk("miso_oe_idle", miso_oe, 0);
    push(8'h01);
    cs_n = 0;
    send_cmd(48'h48_0000_01AA_87, 1'b1, 8'h01);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'hFF);
    cs_hi();
    cs_n = 0;
    send_cmd(48'h51_0000_0000_00, 1'b0, 8'hFF);
    send_cmd(48'h40_0000_0000_97, ~CRC_EN, 8'hFF);
    cs_hi();
    cs_n = 0;
    for (int i = 0; i < 3; i++) begin
      mosi = i[0];
      wait_clk(8);
      sclk = 1;
      wait_clk(8);
      sclk = 0;
    end
    cs_hi();
    chk("rx_data_hold", rx_data, 8'h97);
    cs_n = 0;
    xfer(8'hFF, 8'hFF);
    send_cmd(48'h51_0000_0000_55, 1'b1, 8'hFF);
    cs_hi();
    cs_n = 0;
    xfer(8'h40, 8'hFF);
    xfer(8'h00, 8'hFF);
    cs_hi();
    cs_n = 0;
    send_cmd(48'h40_0000_0000_95, 1'b1, 8'hFF);
    cs_hi();
    for (int i = 0; i < 5; i++) begin
      push(8'hA0 + 8'(i));
      if (i == 3) begin
        chk("full_after_4", resp_full, 1);
        chk("no_overflow_4", resp_overflow, 0);
      end
    end
    chk("overflow_after_5", resp_overflow, 1);
    cs_n = 0;
    for (int i = 0; i < 5; i++) xfer(8'hFF, i < 4 ? 8'hA0 + 8'(i) : 8'hFF);
    cs_hi();
    chk("full_drained", resp_full, 0);
    chk("overflow_sticky", resp_overflow, 1);
    @(negedge clk);
    resp_flush = 1;
    @(negedge clk);
    resp_flush = 0;
    chk("overflow_flushed", resp_overflow, 0);
    for (int i = 0; i < 5; i++) push(8'hB0 + 8'(i));
    chk("full_before_rst", resp_full, 1);
    cs_n = 0;
    xfer(8'h40, 8'hB0);
    xfer(8'h00, 8'hB1);
    xfer(8'h00, 8'hB2);
    wait_clk(4);
    #2 rst = 0;
    #1 chk_reset_outputs();
    cs_n = 1;
    wait_clk(4);
    rst = 1;
    wait_clk(5);
    cs_n = 0;
    send_cmd(48'h40_0000_0000_95, 1'b1, 8'hFF);
    cs_hi();
    wait_clk(20);
    chk("rx_queue_drained", exp_rx.size(), 0);
    chk("cmd_queue_drained", exp_cmd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
